flash_boot_loader: RTL and testbench

FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

---
 rtl/flash_pkg.sv | 22 ++
 rtl/wb_single_xfer.sv | 85 ++++++++
 rtl/flash_boot_loader.sv | 154 +++++++++++++++
 tb/tb_flash_boot_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared state type and bus constants for the flash boot loader
package flash_pkg;

   // Copy sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SET_ADR = 3'd1,
      RD_DAT  = 3'd2,
      WR_RAM  = 3'd3,
      FINISH  = 3'd4,
      FAULT   = 3'd5
   } boot_state_t;

   // Flash slave register offsets from its bus base
   localparam logic [31:0] FLASH_DAT_OFS = 32'h0000_0000;
   localparam logic [31:0] FLASH_ADR_OFS = 32'h0000_0004;

   // Wishbone byte-lane selects
   localparam logic [3:0] WB_SEL_WORD = 4'hF;
   localparam logic [3:0] WB_SEL_NONE = 4'h0;

endpackage

// File: rtl/wb_single_xfer.sv
// rtl/wb_single_xfer.sv - one Wishbone pipelined request: stall handshake, response, retry, timeout
module wb_single_xfer #(
   parameter int TIMEOUT   = 1024,
   parameter int MAX_RETRY = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_ack,
   input  logic i_err,
   input  logic i_rty,
   input  logic i_stall,
   output logic o_stb,
   output logic o_done,
   output logic o_fault
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);

   localparam logic [1:0] X_IDLE = 2'd0;
   localparam logic [1:0] X_REQ  = 2'd1;
   localparam logic [1:0] X_WAIT = 2'd2;

   logic [1:0]    r_phase;
   logic [TW-1:0] r_tmo;
   logic [RW-1:0] r_rty;
   logic          w_wait;
   logic          w_rty_over;
   logic          w_tmo_over;

   // Responses only count while the request is outstanding; err beats ack, ack beats rty
   assign w_wait     = (r_phase == X_WAIT);
   assign w_rty_over = (r_rty == RTY_LAST);
   assign w_tmo_over = (r_tmo == TMO_LAST);
   assign o_stb      = (r_phase == X_REQ);
   assign o_done     = w_wait & i_ack & ~i_err;
   assign o_fault    = w_wait & (i_err
                               | (~i_ack & i_rty & w_rty_over)
                               | (~i_ack & ~i_rty & w_tmo_over));

   // Request / wait sequencing with retry and timeout counters
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_phase <= X_IDLE;
         r_tmo   <= '0;
         r_rty   <= '0;
      end else begin
         case (r_phase)
            X_IDLE: begin
               if (i_en) begin
                  r_phase <= X_REQ;
                  r_rty   <= '0;
               end
            end
            X_REQ: begin
               if (!i_stall) begin
                  r_phase <= X_WAIT;
                  r_tmo   <= '0;
               end
            end
            X_WAIT: begin
               if (i_err || i_ack) begin
                  r_phase <= X_IDLE;
               end else if (i_rty) begin
                  if (w_rty_over) begin
                     r_phase <= X_IDLE;
                  end else begin
                     r_rty   <= r_rty + 1'b1;
                     r_phase <= X_REQ;
                  end
               end else if (w_tmo_over) begin
                  r_phase <= X_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: r_phase <= X_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - copies words from a byte-wide flash register pair into RAM over Wishbone
module flash_boot_loader
   import flash_pkg::*;
#(
   parameter logic [31:0] FLASH_BASE = 32'h0300_0000,
   parameter int          TIMEOUT    = 1024,
   parameter int          MAX_RETRY  = 3
) (
   input  logic        clk_bus,
   input  logic        rst_bus,
   input  logic        start,
   input  logic [22:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] len_words,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic        we_o,
   output logic        cyc_o,
   output logic        stb_o,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i,
   input  logic        stall_i
);

   boot_state_t r_state;
   logic [22:0] r_src;
   logic [31:0] r_dst;
   logic [15:0] r_wcnt;
   logic [1:0]  r_bcnt;
   logic [31:0] r_word;
   logic        r_done;
   logic        r_error;
   logic        w_bus;
   logic        w_xdone;
   logic        w_xfault;
   logic        w_unused_dat;

   assign w_bus        = (r_state == SET_ADR) || (r_state == RD_DAT) || (r_state == WR_RAM);
   assign w_unused_dat = ^dat_i[31:8];
   assign busy         = w_bus;
   assign cyc_o        = w_bus;
   assign done         = r_done;
   assign error        = r_error;

   wb_single_xfer #(
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) u_xfer (
      .i_clk   (clk_bus),
      .i_rst_n (rst_bus),
      .i_en    (w_bus),
      .i_ack   (ack_i),
      .i_err   (err_i),
      .i_rty   (rty_i),
      .i_stall (stall_i),
      .o_stb   (stb_o),
      .o_done  (w_xdone),
      .o_fault (w_xfault)
   );

   // Bus payload decoded from state so it stays stable for the whole request
   always_comb begin
      adr_o = '0;
      dat_o = '0;
      we_o  = 1'b0;
      sel_o = WB_SEL_NONE;
      case (r_state)
         SET_ADR: begin
            adr_o = FLASH_BASE + FLASH_ADR_OFS;
            dat_o = {9'b0, r_src};
            we_o  = 1'b1;
            sel_o = WB_SEL_WORD;
         end
         RD_DAT: begin
            adr_o = FLASH_BASE + FLASH_DAT_OFS;
            sel_o = WB_SEL_WORD;
         end
         WR_RAM: begin
            adr_o = r_dst;
            dat_o = r_word;
            we_o  = 1'b1;
            sel_o = WB_SEL_WORD;
         end
         default: ;
      endcase
   end

   // Copy sequencer: address write, byte read, four bytes per RAM word write
   always_ff @(posedge clk_bus) begin
      if (!rst_bus) begin
         r_state <= IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_wcnt  <= '0;
         r_bcnt  <= '0;
         r_word  <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_done <= (r_state == FINISH);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_src   <= src_addr;
                  r_dst   <= dst_addr;
                  r_wcnt  <= len_words;
                  r_bcnt  <= '0;
                  r_error <= 1'b0;
                  r_state <= (len_words == 16'd0) ? FINISH : SET_ADR;
               end
            end
            SET_ADR: begin
               if (w_xfault) begin
                  r_state <= FAULT;
                  r_error <= 1'b1;
               end else if (w_xdone) begin
                  r_state <= RD_DAT;
               end
            end
            RD_DAT: begin
               if (w_xfault) begin
                  r_state <= FAULT;
                  r_error <= 1'b1;
               end else if (w_xdone) begin
                  r_word[{r_bcnt, 3'b000} +: 8] <= dat_i[7:0];
                  r_src   <= r_src + 23'd1;
                  r_bcnt  <= r_bcnt + 2'd1;
                  r_state <= (r_bcnt == 2'd3) ? WR_RAM : SET_ADR;
               end
            end
            WR_RAM: begin
               if (w_xfault) begin
                  r_state <= FAULT;
                  r_error <= 1'b1;
               end else if (w_xdone) begin
                  r_dst   <= r_dst + 32'd4;
                  r_wcnt  <= r_wcnt - 16'd1;
                  r_state <= (r_wcnt == 16'd1) ? FINISH : SET_ADR;
               end
            end
            FINISH:  r_state <= IDLE;
            FAULT:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - scoreboard bench with a scripted Wishbone slave for flash_boot_loader
module tb_flash_boot_loader;

   localparam logic [31:0] FB   = 32'h0300_0000;
   localparam int          TMO  = 16;
   localparam int          MAXR = 3;

   logic        clk_bus   = 1'b0;
   logic        rst_bus   = 1'b0;
   logic        start     = 1'b0;
   logic [22:0] src_addr  = '0;
   logic [31:0] dst_addr  = '0;
   logic [15:0] len_words = '0;
   logic        busy, done, error;
   logic [31:0] dat_o, adr_o;
   logic [31:0] dat_i     = '0;
   logic [3:0]  sel_o;
   logic        we_o, cyc_o, stb_o;
   logic        ack_i     = 1'b0;
   logic        err_i     = 1'b0;
   logic        rty_i     = 1'b0;
   logic        stall_i   = 1'b0;

   flash_boot_loader #(
      .FLASH_BASE (FB),
      .TIMEOUT    (TMO),
      .MAX_RETRY  (MAXR)
   ) dut (
      .clk_bus   (clk_bus),
      .rst_bus   (rst_bus),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len_words (len_words),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .dat_o     (dat_o),
      .dat_i     (dat_i),
      .adr_o     (adr_o),
      .sel_o     (sel_o),
      .we_o      (we_o),
      .cyc_o     (cyc_o),
      .stb_o     (stb_o),
      .ack_i     (ack_i),
      .err_i     (err_i),
      .rty_i     (rty_i),
      .stall_i   (stall_i)
   );

   always #5 clk_bus = ~clk_bus;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge clk_bus) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t        sb[$];
   logic [7:0] fmem [int];

   // Slave behaviour, written only by the main sequence
   int plan_id       = 0;
   int plan_stall    = 0;
   int plan_rty_idx  = -1;
   int plan_rty_cnt  = 0;
   int plan_delay    = 0;
   bit plan_no_resp  = 1'b0;
   bit plan_ack_err  = 1'b0;

   // Slave observations, written only by the slave process
   int stb_seen = 0;
   int acc_cnt  = 0;
   int rd_acc   = 0;
   int rd_done  = 0;
   int wr_cnt   = 0;
   int ram_wr   = 0;
   int acc_cyc  = 0;
   int sb_rd    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] fbyte(input logic [22:0] a);
      if (fmem.exists(int'(a))) return fmem[int'(a)];
      return a[7:0] ^ 8'h5A;
   endfunction

   // Scripted slave: one-cycle response latency plus optional extra delay
   initial begin : slave
      int          seen;
      bit          pend;
      bit          stall_on;
      int          s_stall;
      int          s_rty;
      int          dly;
      logic [31:0] acc_adr, acc_dat, ref_adr, ref_dat;
      logic        acc_we;
      logic [22:0] cur_fa;
      seen = 0; pend = 0; stall_on = 0; s_stall = 0; s_rty = 0; dly = 0;
      acc_adr = '0; acc_dat = '0; ref_adr = '0; ref_dat = '0; acc_we = 1'b0; cur_fa = '0;
      forever begin
         @(negedge clk_bus);
         ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; stall_i = 1'b0;
         if (plan_id != seen) begin
            seen = plan_id; pend = 0; stall_on = 0;
            s_stall = plan_stall; s_rty = plan_rty_cnt;
            stb_seen = 0; acc_cnt = 0; rd_acc = 0; rd_done = 0;
            wr_cnt = 0; ram_wr = 0; sb_rd = 0;
         end
         if (stb_o) stb_seen++;
         if (pend) begin
            if (dly > 0) begin
               dly--;
            end else if (!plan_no_resp) begin
               pend = 0;
               if (plan_ack_err) begin
                  ack_i = 1'b1; err_i = 1'b1;
               end else if (!acc_we && rd_done == plan_rty_idx && s_rty > 0) begin
                  rty_i = 1'b1; s_rty--;
               end else begin
                  ack_i = 1'b1;
                  if (!acc_we) begin
                     dat_i = {24'($urandom()), fbyte(cur_fa)};
                     rd_done++;
                  end else begin
                     wr_cnt++;
                     if (acc_adr == FB + 32'd4) cur_fa = acc_dat[22:0];
                     else ram_wr++;
                     if (sb_rd < sb.size()) begin
                        check("wr_adr", acc_adr, sb[sb_rd].adr);
                        check("wr_dat", acc_dat, sb[sb_rd].dat);
                        sb_rd++;
                     end
                  end
               end
            end
         end else if (stb_o || stall_on) begin
            if (s_stall > 0) begin
               if (!stall_on) begin
                  stall_on = 1; ref_adr = adr_o; ref_dat = dat_o;
               end else begin
                  check("stall_stb", 32'(stb_o), 1);
                  check("stall_adr", adr_o, ref_adr);
                  check("stall_dat", dat_o, ref_dat);
               end
               stall_i = 1'b1;
               s_stall--;
            end else begin
               if (stall_on) begin
                  check("stall_stb", 32'(stb_o), 1);
                  check("stall_adr", adr_o, ref_adr);
                  stall_on = 0;
               end
               if (stb_o) begin
                  pend = 1; dly = plan_delay;
                  acc_adr = adr_o; acc_dat = dat_o; acc_we = we_o;
                  acc_cnt++;
                  if (!we_o) rd_acc++;
                  acc_cyc = cyc + 1;
               end
            end
         end
      end
   end

   task automatic new_plan(input int stall, input int rty_idx, input int rty_cnt,
                           input int dly, input bit no_resp, input bit ack_err);
      plan_stall = stall; plan_rty_idx = rty_idx; plan_rty_cnt = rty_cnt;
      plan_delay = dly; plan_no_resp = no_resp; plan_ack_err = ack_err;
      sb.delete();
      plan_id++;
      @(posedge clk_bus); #1;
   endtask

   task automatic push_copy(input logic [22:0] s, input logic [31:0] d, input int n);
      logic [31:0] w;
      logic [22:0] a;
      logic [31:0] da;
      a = s; da = d;
      for (int i = 0; i < n; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++) begin
            sb.push_back('{adr: FB + 32'd4, dat: {9'b0, a}});
            w[8*k +: 8] = fbyte(a);
            a = a + 23'd1;
         end
         sb.push_back('{adr: da, dat: w});
         da = da + 32'd4;
      end
   endtask

   task automatic start_copy(input logic [22:0] s, input logic [31:0] d, input logic [15:0] n);
      src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
      @(posedge clk_bus); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(output bit gd, output bit ge);
      for (int i = 0; i < 2000; i++) begin
         if (done || error) break;
         @(posedge clk_bus); #1;
      end
      gd = done; ge = error;
      if (!(done || error)) check("end_bound", 32'(done | error), 1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin : main
      bit gd, ge;
      gd = 0; ge = 0;

      // Reset values
      rst_bus = 1'b0;
      repeat (3) @(posedge clk_bus);
      #1;
      check("rst_cyc",   32'(cyc_o), 0);
      check("rst_stb",   32'(stb_o), 0);
      check("rst_we",    32'(we_o),  0);
      check("rst_sel",   32'(sel_o), 0);
      check("rst_adr",   adr_o, 0);
      check("rst_dat",   dat_o, 0);
      check("rst_busy",  32'(busy),  0);
      check("rst_done",  32'(done),  0);
      check("rst_error", 32'(error), 0);
      rst_bus = 1'b1;
      @(posedge clk_bus); #1;

      // Basic one-word copy with a 5-cycle stall on the first request
      fmem[32'h10] = 8'h11; fmem[32'h11] = 8'h22;
      fmem[32'h12] = 8'h33; fmem[32'h13] = 8'h44;
      new_plan(5, -1, 0, 0, 1'b0, 1'b0);
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0010});
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0011});
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0012});
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0013});
      sb.push_back('{adr: 32'h8000_0000, dat: 32'h4433_2211});
      start_copy(23'h000010, 32'h8000_0000, 16'd1);
      check("t1_busy", 32'(busy), 1);
      wait_end(gd, ge);
      check("t1_done", 32'(gd), 1);
      check("t1_err",  32'(ge), 0);
      @(posedge clk_bus); #1;
      check("t1_done_pulse", 32'(done),  0);
      check("t1_busy_end",   32'(busy),  0);
      check("t1_cyc_end",    32'(cyc_o), 0);
      check("t1_writes",     wr_cnt, 5);
      check("t1_sb",         sb_rd, sb.size());
      check("t1_acc",        acc_cnt, 9);

      // Two retries on the second read: transfer reissued, copy completes
      new_plan(0, 1, 2, 0, 1'b0, 1'b0);
      push_copy(23'h000020, 32'h0000_0100, 2);
      start_copy(23'h000020, 32'h0000_0100, 16'd2);
      wait_end(gd, ge);
      check("t2_done",   32'(gd), 1);
      check("t2_err",    32'(ge), 0);
      check("t2_rd_acc", rd_acc, 10);
      check("t2_writes", wr_cnt, 10);
      check("t2_sb",     sb_rd, sb.size());

      // Four retries on the second read: fault
      new_plan(0, 1, 4, 0, 1'b0, 1'b0);
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0030});
      sb.push_back('{adr: FB + 32'd4, dat: 32'h0000_0031});
      start_copy(23'h000030, 32'h0000_0200, 16'd1);
      wait_end(gd, ge);
      check("t3_err",    32'(ge), 1);
      check("t3_done",   32'(gd), 0);
      check("t3_cyc",    32'(cyc_o), 0);
      check("t3_busy",   32'(busy), 0);
      check("t3_rd_acc", rd_acc, 5);
      check("t3_writes", wr_cnt, 2);
      check("t3_sb",     sb_rd, sb.size());
      @(posedge clk_bus); #1;
      check("t3_err_sticky", 32'(error), 1);

      // Silent slave: fault exactly TIMEOUT cycles after acceptance
      new_plan(0, -1, 0, 0, 1'b1, 1'b0);
      start_copy(23'h000040, 32'h0000_0300, 16'd1);
      check("t4_err_clr", 32'(error), 0);
      wait_end(gd, ge);
      check("t4_err",     32'(ge), 1);
      check("t4_tmo_cyc", cyc - acc_cyc, TMO);
      check("t4_cyc",     32'(cyc_o), 0);
      check("t4_acc",     acc_cnt, 1);

      // ack and err together: err wins
      new_plan(0, -1, 0, 0, 1'b0, 1'b1);
      start_copy(23'h000050, 32'h0000_0400, 16'd1);
      wait_end(gd, ge);
      check("t5_err",  32'(ge), 1);
      check("t5_done", 32'(gd), 0);
      check("t5_acc",  acc_cnt, 1);

      // Zero length: no bus activity, done two cycles after start
      new_plan(0, -1, 0, 0, 1'b0, 1'b0);
      start_copy(23'h000060, 32'h0000_0500, 16'd0);
      check("t6_done_early", 32'(done), 0);
      check("t6_err_clr",    32'(error), 0);
      @(posedge clk_bus); #1;
      check("t6_done", 32'(done), 1);
      @(posedge clk_bus); #1;
      check("t6_done_pulse", 32'(done), 0);
      repeat (3) @(posedge clk_bus);
      #1;
      check("t6_stb", stb_seen, 0);
      check("t6_acc", acc_cnt, 0);

      // Source and destination address wrap
      new_plan(0, -1, 0, 0, 1'b0, 1'b0);
      push_copy(23'h7FFFFF, 32'hFFFF_FFFC, 2);
      start_copy(23'h7FFFFF, 32'hFFFF_FFFC, 16'd2);
      wait_end(gd, ge);
      check("t7_done",   32'(gd), 1);
      check("t7_err",    32'(ge), 0);
      check("t7_writes", wr_cnt, 10);
      check("t7_sb",     sb_rd, sb.size());

      // Reset during a read, slave answers late
      new_plan(0, -1, 0, 3, 1'b0, 1'b0);
      start_copy(23'h000070, 32'h0000_0600, 16'd1);
      for (int i = 0; i < 200; i++) begin
         if (rd_acc > 0) break;
         @(posedge clk_bus); #1;
      end
      check("t8_rd_seen", 32'(rd_acc > 0), 1);
      rst_bus = 1'b0;
      @(posedge clk_bus); #1;
      check("t8_cyc_rst", 32'(cyc_o), 0);
      check("t8_stb_rst", 32'(stb_o), 0);
      rst_bus = 1'b1;
      repeat (5) @(posedge clk_bus);
      #1;
      check("t8_cyc",    32'(cyc_o), 0);
      check("t8_stb",    32'(stb_o), 0);
      check("t8_we",     32'(we_o),  0);
      check("t8_sel",    32'(sel_o), 0);
      check("t8_adr",    adr_o, 0);
      check("t8_dat",    dat_o, 0);
      check("t8_busy",   32'(busy),  0);
      check("t8_done",   32'(done),  0);
      check("t8_error",  32'(error), 0);
      check("t8_ram_wr", ram_wr, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
